// File: rtl/cmd_reg_arbiter.sv
// Command-register bank shared by several write requesters.
// Grants one write per three-cycle transaction (IDLE -> WRITE -> DONE),
// either round-robin or with requester 0 as fixed top priority, holds the
// bank as registered 16-bit words and pulses a per-word write strobe.
module cmd_reg_arbiter #(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned PRIO0     = 1,
   parameter int unsigned BASE_ADDR = 24,
   parameter int unsigned NWORDS    = 19,
   parameter int unsigned AW        = 10
) (
   input  logic                   SYS_CLK,
   input  logic                   SYS_RST_N,
   input  logic                   LOCK,
   input  logic [NREQ-1:0]        REQ_VALID,
   input  logic [NREQ*AW-1:0]     REQ_ADDR,
   input  logic [NREQ*16-1:0]     REQ_DATA,
   output logic [NREQ-1:0]        REQ_READY,
   output logic [NREQ-1:0]        REQ_ERR,
   output logic [NWORDS*16-1:0]   CMD_REG,
   output logic [NWORDS-1:0]      WR_STROBE,
   output logic                   BUSY
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW-1:0] BASE_A   = AW'(BASE_ADDR);
   localparam logic [AW-1:0] NWORDS_A = AW'(NWORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gnt_hold;
   logic [AW-1:0]   addr_hold;
   logic [15:0]     data_hold;

   logic [IW-1:0]   gnt_next;
   logic            gnt_found;
   logic [2*NREQ-1:0] valid_dbl;
   logic [NREQ-1:0] valid_rot;
   logic [AW-1:0]   off;
   logic            in_win;

   // Winner selection: requester 0 override, else first valid after ptr.
   // The valid vector is rotated so bit 0 is requester ptr+1.
   always_comb begin
      gnt_found = 1'b0;
      gnt_next  = '0;
      valid_dbl = {REQ_VALID, REQ_VALID};
      valid_rot = NREQ'(valid_dbl >> (32'(ptr) + 1));
      if (PRIO0 != 0 && REQ_VALID[0]) begin
         gnt_found = 1'b1;
         gnt_next  = '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && valid_rot[k]) begin
               gnt_found = 1'b1;
               gnt_next  = IW'((32'(ptr) + 1 + k) % NREQ);
            end
         end
      end
   end

   // Window decode: addresses below BASE wrap to large offsets and fail the bound.
   always_comb begin
      off    = addr_hold - BASE_A;
      in_win = (off < NWORDS_A);
   end

   // Transaction FSM with registered handshake, strobe and register bank.
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state     <= S_IDLE;
         ptr       <= IW'(NREQ - 1);
         gnt_hold  <= '0;
         addr_hold <= '0;
         data_hold <= '0;
         REQ_READY <= '0;
         REQ_ERR   <= '0;
         CMD_REG   <= '0;
         WR_STROBE <= '0;
         BUSY      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!LOCK && gnt_found) begin
                  gnt_hold  <= gnt_next;
                  addr_hold <= REQ_ADDR[gnt_next*AW +: AW];
                  data_hold <= REQ_DATA[gnt_next*16 +: 16];
                  BUSY      <= 1'b1;
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               for (int unsigned k = 0; k < NWORDS; k++) begin
                  if (in_win && off == AW'(k)) begin
                     CMD_REG[k*16 +: 16] <= data_hold;
                     WR_STROBE[k]        <= 1'b1;
                  end
               end
               REQ_READY[gnt_hold] <= 1'b1;
               REQ_ERR[gnt_hold]   <= ~in_win;
               ptr                 <= gnt_hold;
               state               <= S_DONE;
            end
            S_DONE: begin
               REQ_READY <= '0;
               REQ_ERR   <= '0;
               WR_STROBE <= '0;
               BUSY      <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_reg_arbiter.sv
// Directed bench for cmd_reg_arbiter: one instance with requester-0
// priority (dut) and one pure round-robin instance (dut_rr).
module tb_cmd_reg_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 10;
   localparam int NW   = 19;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic                 a_lock, r_lock;
   logic [NREQ-1:0]      a_valid, r_valid;
   logic [NREQ*AW-1:0]   a_addr, r_addr;
   logic [NREQ*16-1:0]   a_data, r_data;
   logic [NREQ-1:0]      a_ready, r_ready, a_err, r_err;
   logic [NW*16-1:0]     a_cmd, r_cmd;
   logic [NW-1:0]        a_strobe, r_strobe;
   logic                 a_busy, r_busy;

   logic [NW*16-1:0]     exp_a, exp_r;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cmd_reg_arbiter #(.PRIO0(1)) dut (
      .SYS_CLK(clk), .SYS_RST_N(rst_n), .LOCK(a_lock),
      .REQ_VALID(a_valid), .REQ_ADDR(a_addr), .REQ_DATA(a_data),
      .REQ_READY(a_ready), .REQ_ERR(a_err), .CMD_REG(a_cmd),
      .WR_STROBE(a_strobe), .BUSY(a_busy)
   );

   cmd_reg_arbiter #(.PRIO0(0)) dut_rr (
      .SYS_CLK(clk), .SYS_RST_N(rst_n), .LOCK(r_lock),
      .REQ_VALID(r_valid), .REQ_ADDR(r_addr), .REQ_DATA(r_data),
      .REQ_READY(r_ready), .REQ_ERR(r_err), .CMD_REG(r_cmd),
      .WR_STROBE(r_strobe), .BUSY(r_busy)
   );

   task automatic test_reset();
      a_lock = 0; r_lock = 0;
      a_valid = '0; r_valid = '0;
      a_addr = '0; r_addr = '0;
      a_data = '0; r_data = '0;
      exp_a = '0; exp_r = '0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({a_ready, a_err, a_strobe, a_busy, a_cmd} !== '0) begin
         failures++;
         $display("FAIL reset_in: dut outputs got ready=%b err=%b strobe=%h busy=%b want all 0",
                  a_ready, a_err, a_strobe, a_busy);
      end
      rst_n = 1;
      @(negedge clk);
      checks++;
      if ({a_ready, a_err, a_strobe, a_busy, a_cmd, r_ready, r_err, r_strobe, r_busy, r_cmd} !== '0) begin
         failures++;
         $display("FAIL reset_out: got a_busy=%b r_busy=%b a_ready=%b r_ready=%b want all 0",
                  a_busy, r_busy, a_ready, r_ready);
      end
   endtask

   task automatic test_single();
      a_valid = 3'b001;
      a_addr[0 +: AW] = 10'd24;
      a_data[0 +: 16] = 16'hBEEF;
      exp_a[0 +: 16] = 16'hBEEF;
      @(negedge clk);
      checks++;
      if (a_ready !== 3'b000 || a_busy !== 1'b1) begin
         failures++;
         $display("FAIL single_write_state: got ready=%b busy=%b want 000/1", a_ready, a_busy);
      end
      @(negedge clk);
      checks++;
      if (a_ready !== 3'b001 || a_err !== 3'b000 || a_busy !== 1'b1) begin
         failures++;
         $display("FAIL single_ready: got ready=%b err=%b busy=%b want 001/000/1", a_ready, a_err, a_busy);
      end
      checks++;
      if (a_strobe !== 19'h1 || a_cmd !== exp_a) begin
         failures++;
         $display("FAIL single_data: got strobe=%h word0=%h want 00001/beef", a_strobe, a_cmd[15:0]);
      end
      a_valid = '0;
      @(negedge clk);
      checks++;
      if (a_ready !== 3'b000 || a_strobe !== '0 || a_busy !== 1'b0) begin
         failures++;
         $display("FAIL single_done: got ready=%b strobe=%h busy=%b want 000/0/0", a_ready, a_strobe, a_busy);
      end
   endtask

   task automatic test_round_robin();
      int order[4] = '{0, 1, 2, 0};
      logic [NREQ-1:0] exp_rdy;
      logic [NW-1:0]   exp_stb;
      r_valid = 3'b111;
      r_addr[0*AW +: AW] = 10'd30; r_data[0*16 +: 16] = 16'hA000;
      r_addr[1*AW +: AW] = 10'd31; r_data[1*16 +: 16] = 16'hA111;
      r_addr[2*AW +: AW] = 10'd32; r_data[2*16 +: 16] = 16'hA222;
      exp_r[6*16 +: 16] = 16'hA000;
      exp_r[7*16 +: 16] = 16'hA111;
      exp_r[8*16 +: 16] = 16'hA222;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         exp_rdy = (i % 3 == 1) ? (3'b001 << order[i/3]) : 3'b000;
         exp_stb = (i % 3 == 1) ? (19'h1 << (6 + order[i/3])) : 19'h0;
         checks++;
         if (r_ready !== exp_rdy || r_strobe !== exp_stb) begin
            failures++;
            $display("FAIL rr_cycle%0d: got ready=%b strobe=%h want %b/%h", i, r_ready, r_strobe, exp_rdy, exp_stb);
         end
         if (i == 11) r_valid = '0;
      end
      checks++;
      if (r_cmd !== exp_r) begin
         failures++;
         $display("FAIL rr_words: got %h want %h", r_cmd, exp_r);
      end
   endtask

   task automatic test_prio0();
      logic [NREQ-1:0] exp_rdy;
      a_valid = 3'b101;
      a_addr[0*AW +: AW] = 10'd25; a_data[0*16 +: 16] = 16'h1111;
      a_addr[2*AW +: AW] = 10'd26; a_data[2*16 +: 16] = 16'h2222;
      exp_a[1*16 +: 16] = 16'h1111;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exp_rdy = (i % 3 == 1) ? 3'b001 : 3'b000;
         checks++;
         if (a_ready !== exp_rdy) begin
            failures++;
            $display("FAIL prio_cycle%0d: got ready=%b want %b", i, a_ready, exp_rdy);
         end
         if (i == 8) a_valid = '0;
      end
      checks++;
      if (a_cmd !== exp_a) begin
         failures++;
         $display("FAIL prio_words: got %h want %h", a_cmd, exp_a);
      end
   endtask

   task automatic test_window();
      logic [AW-1:0] addrs[4] = '{10'd10, 10'd43, 10'd23, 10'd42};
      bit            ok[4]    = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [NW-1:0] exp_stb;
      for (int t = 0; t < 4; t++) begin
         a_valid = 3'b010;
         a_addr[1*AW +: AW] = addrs[t];
         a_data[1*16 +: 16] = 16'hD000 + 16'(t);
         if (ok[t]) exp_a[18*16 +: 16] = 16'hD000 + 16'(t);
         exp_stb = ok[t] ? 19'h40000 : 19'h0;
         for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (a_ready !== 3'b000) break;
         end
         checks++;
         if (a_ready !== 3'b010 || a_err !== (ok[t] ? 3'b000 : 3'b010)) begin
            failures++;
            $display("FAIL window_hs addr=%0d: got ready=%b err=%b want 010/%b",
                     addrs[t], a_ready, a_err, ok[t] ? 3'b000 : 3'b010);
         end
         checks++;
         if (a_strobe !== exp_stb || a_cmd !== exp_a) begin
            failures++;
            $display("FAIL window_data addr=%0d: got strobe=%h cmd=%h want %h/%h",
                     addrs[t], a_strobe, a_cmd, exp_stb, exp_a);
         end
         a_valid = '0;
         @(negedge clk);
      end
   endtask

   task automatic test_lock();
      a_lock = 1;
      a_valid = 3'b010;
      a_addr[1*AW +: AW] = 10'd27;
      a_data[1*16 +: 16] = 16'h3333;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (a_ready !== 3'b000 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL lock_hold%0d: got ready=%b busy=%b want 000/0", i, a_ready, a_busy);
         end
      end
      a_lock = 0;
      exp_a[3*16 +: 16] = 16'h3333;
      @(negedge clk);
      checks++;
      if (a_ready !== 3'b000 || a_busy !== 1'b1) begin
         failures++;
         $display("FAIL lock_release_write: got ready=%b busy=%b want 000/1", a_ready, a_busy);
      end
      @(negedge clk);
      checks++;
      if (a_ready !== 3'b010 || a_strobe !== 19'h8 || a_cmd !== exp_a) begin
         failures++;
         $display("FAIL lock_release_done: got ready=%b strobe=%h want 010/00008", a_ready, a_strobe);
      end
      a_valid = '0;
      @(negedge clk);
      // LOCK raised while the write is in flight
      a_valid = 3'b010;
      a_addr[1*AW +: AW] = 10'd28;
      a_data[1*16 +: 16] = 16'h4444;
      exp_a[4*16 +: 16] = 16'h4444;
      @(negedge clk);
      a_lock = 1;
      @(negedge clk);
      checks++;
      if (a_ready !== 3'b010 || a_strobe !== 19'h10 || a_cmd !== exp_a) begin
         failures++;
         $display("FAIL lock_inflight: got ready=%b strobe=%h word4=%h want 010/00010/4444",
                  a_ready, a_strobe, a_cmd[4*16 +: 16]);
      end
      a_valid = '0;
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin
         failures++;
         $display("FAIL lock_inflight_idle: got busy=%b want 0", a_busy);
      end
      a_lock = 0;
   endtask

   task automatic test_reset_mid_write();
      a_valid = 3'b001;
      a_addr[0*AW +: AW] = 10'd29; a_data[0*16 +: 16] = 16'h5555;
      r_valid = 3'b010;
      r_addr[1*AW +: AW] = 10'd33; r_data[1*16 +: 16] = 16'h6666;
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b1 || r_busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre: got a_busy=%b r_busy=%b want 1/1", a_busy, r_busy);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({a_ready, a_busy, a_cmd, r_ready, r_busy, r_cmd} !== '0) begin
         failures++;
         $display("FAIL rst_async: got a_ready=%b a_busy=%b r_ready=%b r_busy=%b cmd nonzero=%b want all 0",
                  a_ready, a_busy, r_ready, r_busy, (a_cmd != '0) || (r_cmd != '0));
      end
      exp_a = '0; exp_r = '0;
      a_valid = '0; r_valid = '0;
      @(negedge clk);
      rst_n = 1;
      r_valid = 3'b111;
      r_addr[0*AW +: AW] = 10'd30; r_data[0*16 +: 16] = 16'hB000;
      r_addr[1*AW +: AW] = 10'd31; r_data[1*16 +: 16] = 16'hB111;
      r_addr[2*AW +: AW] = 10'd32; r_data[2*16 +: 16] = 16'hB222;
      exp_r[6*16 +: 16] = 16'hB000;
      repeat (2) @(negedge clk);
      checks++;
      if (r_ready !== 3'b001 || r_strobe !== 19'h40) begin
         failures++;
         $display("FAIL rst_first_grant: got ready=%b strobe=%h want 001/00040", r_ready, r_strobe);
      end
      r_valid = '0;
      @(negedge clk);
      checks++;
      if (r_cmd !== exp_r || a_cmd !== exp_a) begin
         failures++;
         $display("FAIL rst_words: got r_cmd=%h a_cmd=%h want %h/%h", r_cmd, a_cmd, exp_r, exp_a);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_prio0();
      test_window();
      test_lock();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
